// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer
// Turns one register read/write request into the byte-command sequence of the
// byte-level I2C controller: START+address, register, data, and for reads a
// repeated START followed by a master-received byte. Checks slave ACKs, issues a
// STOP recovery byte after a NACK, and guards every byte with a watchdog.

module i2c_reg_sequencer #(
    parameter int C_TIMEOUT_LOG2 = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rnw,
    input  logic [6:0]  req_dev_addr,
    input  logic [7:0]  req_reg_addr,
    input  logic [7:0]  req_wdata,

    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        resp_nack,
    output logic [1:0]  resp_nack_byte,
    output logic        resp_timeout,

    output logic        i2c_cmd_pulse_o,
    output logic [10:0] i2c_ctrl_reg_o,
    input  logic [9:0]  i2c_status_reg_i,
    input  logic        i2c_irq_i,
    output logic        i2c_irq_ack_pulse_o
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        RECOVER_ISSUE,
        RECOVER_WAIT,
        DONE
    } state_t;

    localparam logic [C_TIMEOUT_LOG2-1:0] WD_MAX = {C_TIMEOUT_LOG2{1'b1}};

    // A STOP-terminated dummy write that releases the bus after a NACK.
    localparam logic [10:0] RECOVER_WORD = {3'b101, 8'hFF};

    state_t state_q, state_d;

    logic [1:0]                bidx_q, bidx_d;
    logic                      rnw_q, rnw_d;
    logic [6:0]                dev_q, dev_d;
    logic [7:0]                reg_q, reg_d;
    logic [7:0]                wdata_q, wdata_d;
    logic [10:0]               ctrl_q, ctrl_d;
    logic [8:0]                status_q, status_d;
    logic [C_TIMEOUT_LOG2-1:0] wd_q, wd_d;
    logic [7:0]                rdata_q, rdata_d;
    logic                      nack_q, nack_d;
    logic [1:0]                nack_byte_q, nack_byte_d;
    logic                      timeout_q, timeout_d;
    logic                      recover_ack_q, recover_ack_d;
    logic                      status_busy_unused;

    // The controller's busy flag carries no information once its IRQ is up.
    assign status_busy_unused = i2c_status_reg_i[9];

    // Control word {we, start, stop, data} for byte idx of a transaction.
    function automatic logic [10:0] byte_word(
        input logic [1:0] idx,
        input logic       rnw,
        input logic [6:0] dev,
        input logic [7:0] rega,
        input logic [7:0] wdata
    );
        logic [10:0] word;
        case (idx)
            2'd0:    word = {3'b110, dev, 1'b0};
            2'd1:    word = {3'b100, rega};
            2'd2:    word = rnw ? {3'b110, dev, 1'b1} : {3'b101, wdata};
            default: word = {3'b001, 8'h00};
        endcase
        return word;
    endfunction

    assign req_ready           = (state_q == IDLE) && !rst;
    assign resp_valid          = (state_q == DONE);
    assign i2c_cmd_pulse_o     = (state_q == ISSUE) || (state_q == RECOVER_ISSUE);
    assign i2c_irq_ack_pulse_o = (state_q == CHECK) || recover_ack_q;
    assign i2c_ctrl_reg_o      = ctrl_q;
    assign resp_rdata          = rdata_q;
    assign resp_nack           = nack_q;
    assign resp_nack_byte      = nack_byte_q;
    assign resp_timeout        = timeout_q;

    // Next-state and datapath updates for the byte sequencing FSM.
    always_comb begin
        state_d       = state_q;
        bidx_d        = bidx_q;
        rnw_d         = rnw_q;
        dev_d         = dev_q;
        reg_d         = reg_q;
        wdata_d       = wdata_q;
        ctrl_d        = ctrl_q;
        status_d      = status_q;
        wd_d          = wd_q;
        rdata_d       = rdata_q;
        nack_d        = nack_q;
        nack_byte_d   = nack_byte_q;
        timeout_d     = timeout_q;
        recover_ack_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rnw_d       = req_rnw;
                    dev_d       = req_dev_addr;
                    reg_d       = req_reg_addr;
                    wdata_d     = req_wdata;
                    bidx_d      = 2'd0;
                    rdata_d     = 8'h00;
                    nack_d      = 1'b0;
                    nack_byte_d = 2'd0;
                    timeout_d   = 1'b0;
                    ctrl_d      = byte_word(2'd0, req_rnw, req_dev_addr,
                                            req_reg_addr, req_wdata);
                    state_d     = ISSUE;
                end
            end

            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end

            WAIT: begin
                wd_d = wd_q + 1'b1;
                if (i2c_irq_i) begin
                    status_d = i2c_status_reg_i[8:0];
                    state_d  = CHECK;
                end else if (wd_d == WD_MAX) begin
                    timeout_d = 1'b1;
                    ctrl_d    = '0;
                    state_d   = DONE;
                end
            end

            CHECK: begin
                if (ctrl_q[10] && !status_q[8]) begin
                    nack_d      = 1'b1;
                    nack_byte_d = bidx_q;
                    ctrl_d      = RECOVER_WORD;
                    state_d     = RECOVER_ISSUE;
                end else if (bidx_q == (rnw_q ? 2'd3 : 2'd2)) begin
                    if (rnw_q) begin
                        rdata_d = status_q[7:0];
                    end
                    ctrl_d  = '0;
                    state_d = DONE;
                end else begin
                    bidx_d  = bidx_q + 2'd1;
                    ctrl_d  = byte_word(bidx_q + 2'd1, rnw_q, dev_q, reg_q, wdata_q);
                    state_d = ISSUE;
                end
            end

            RECOVER_ISSUE: begin
                wd_d    = '0;
                state_d = RECOVER_WAIT;
            end

            RECOVER_WAIT: begin
                wd_d = wd_q + 1'b1;
                if (i2c_irq_i) begin
                    recover_ack_d = 1'b1;
                    ctrl_d        = '0;
                    state_d       = DONE;
                end else if (wd_d == WD_MAX) begin
                    timeout_d = 1'b1;
                    ctrl_d    = '0;
                    state_d   = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request, control-word, watchdog and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bidx_q        <= '0;
            rnw_q         <= 1'b0;
            dev_q         <= '0;
            reg_q         <= '0;
            wdata_q       <= '0;
            ctrl_q        <= '0;
            status_q      <= '0;
            wd_q          <= '0;
            rdata_q       <= '0;
            nack_q        <= 1'b0;
            nack_byte_q   <= '0;
            timeout_q     <= 1'b0;
            recover_ack_q <= 1'b0;
        end else begin
            bidx_q        <= bidx_d;
            rnw_q         <= rnw_d;
            dev_q         <= dev_d;
            reg_q         <= reg_d;
            wdata_q       <= wdata_d;
            ctrl_q        <= ctrl_d;
            status_q      <= status_d;
            wd_q          <= wd_d;
            rdata_q       <= rdata_d;
            nack_q        <= nack_d;
            nack_byte_q   <= nack_byte_d;
            timeout_q     <= timeout_d;
            recover_ack_q <= recover_ack_d;
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer
// Drives i2c_reg_sequencer against a behavioural byte controller with a slave
// at address 0x50, using a table of register transactions plus hand-written
// sequences for timeout, back-to-back requests and reset mid-transaction.

module tb_i2c_reg_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_rnw;
    logic [6:0]  req_dev_addr;
    logic [7:0]  req_reg_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        resp_nack;
    logic [1:0]  resp_nack_byte;
    logic        resp_timeout;
    logic        cmd_pulse;
    logic [10:0] ctrl_word;
    logic [9:0]  i2c_status;
    logic        i2c_irq;
    logic        irq_ack;

    int n_cmp  = 0;
    int n_fail = 0;

    i2c_reg_sequencer #(.C_TIMEOUT_LOG2(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_rnw             (req_rnw),
        .req_dev_addr        (req_dev_addr),
        .req_reg_addr        (req_reg_addr),
        .req_wdata           (req_wdata),
        .resp_valid          (resp_valid),
        .resp_rdata          (resp_rdata),
        .resp_nack           (resp_nack),
        .resp_nack_byte      (resp_nack_byte),
        .resp_timeout        (resp_timeout),
        .i2c_cmd_pulse_o     (cmd_pulse),
        .i2c_ctrl_reg_o      (ctrl_word),
        .i2c_status_reg_i    (i2c_status),
        .i2c_irq_i           (i2c_irq),
        .i2c_irq_ack_pulse_o (irq_ack)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Behavioural controller and slave knobs.
    bit          force_irq_low = 1'b0;
    bit          nack_reg      = 1'b0;
    bit          nack_data     = 1'b0;
    int          busy;
    logic [10:0] cur;
    logic        sel;
    logic        phase;
    logic [7:0]  reg_ptr;
    logic [7:0]  mem [256];
    logic        m_ack;
    logic [7:0]  m_data;

    // Byte controller model: completes each byte 3 cycles after its command,
    // raises a sticky IRQ with {busy, ack, data}, and drops it on irq_ack.
    always @(negedge clk) begin
        if (rst) begin
            i2c_irq    = 1'b0;
            i2c_status = '0;
            busy       = 0;
            sel        = 1'b0;
            phase      = 1'b0;
            reg_ptr    = '0;
            for (int i = 0; i < 256; i++) mem[i] = 8'h00;
            mem[8'h12] = 8'h3C;
        end else begin
            if (irq_ack) i2c_irq = 1'b0;
            if (cmd_pulse) begin
                cur  = ctrl_word;
                busy = 3;
            end else if (busy > 0) begin
                busy = busy - 1;
                if (busy == 0 && !force_irq_low) begin
                    m_data = cur[7:0];
                    m_ack  = 1'b0;
                    if (cur[9]) begin
                        sel   = (cur[7:1] == 7'h50);
                        phase = 1'b0;
                        m_ack = sel;
                    end else if (cur[10]) begin
                        if (!sel) begin
                            m_ack = 1'b0;
                        end else if (!phase) begin
                            reg_ptr = cur[7:0];
                            phase   = 1'b1;
                            m_ack   = !nack_reg;
                            if (nack_reg) sel = 1'b0;
                        end else begin
                            m_ack = !nack_data;
                            if (!nack_data) mem[reg_ptr] = cur[7:0];
                            else sel = 1'b0;
                        end
                    end else begin
                        m_data = sel ? mem[reg_ptr] : 8'hFF;
                        m_ack  = 1'b1;
                    end
                    if (cur[8]) sel = 1'b0;
                    i2c_status = {1'b0, m_ack, m_data};
                    i2c_irq    = 1'b1;
                end
            end
        end
    end

    // Monitor: logs command words, counts IRQ acks and responses.
    int          cyc         = 0;
    int          nlog        = 0;
    logic [10:0] log_word [16];
    int          log_cyc  [16];
    int          ack_pulses  = 0;
    int          resp_count  = 0;
    int          resp_cyc    = 0;
    int          overlap     = 0;
    logic [7:0]  got_rdata;
    logic        got_nack;
    logic [1:0]  got_nack_byte;
    logic        got_timeout;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cmd_pulse) begin
            if (nlog < 16) begin
                log_word[nlog] = ctrl_word;
                log_cyc[nlog]  = cyc;
            end
            nlog = nlog + 1;
        end
        if (irq_ack) ack_pulses = ack_pulses + 1;
        if (resp_valid) begin
            resp_count    = resp_count + 1;
            resp_cyc      = cyc;
            got_rdata     = resp_rdata;
            got_nack      = resp_nack;
            got_nack_byte = resp_nack_byte;
            got_timeout   = resp_timeout;
        end
        if (resp_valid && req_ready) overlap = overlap + 1;
    end

    typedef struct {
        logic              rnw;
        logic [6:0]        dev;
        logic [7:0]        rega;
        logic [7:0]        wdata;
        bit                nack_reg;
        bit                nack_data;
        int                npulses;
        logic [0:4][10:0]  words;
        logic [7:0]        rdata;
        logic              nack;
        logic [1:0]        nack_byte;
    } vec_t;

    vec_t vecs [9];

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_resp(input int target, input int budget, input string name);
        int k = 0;
        while (resp_count < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (resp_count < target) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s: no resp_valid within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_log(input int target, input int budget, input string name);
        int k = 0;
        while (nlog < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (nlog < target) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL %s: only %0d cmd pulses within %0d cycles", name, nlog, budget);
        end
    endtask

    task automatic clear_log();
        nlog = 0;
        for (int i = 0; i < 16; i++) begin
            log_word[i] = '0;
            log_cyc[i]  = 0;
        end
    endtask

    // Runs one table entry end to end and compares every observable result.
    task automatic apply_stimulus(input int idx, input vec_t v);
        int base;
        int ack_base;
        @(posedge clk);
        clear_log();
        nack_reg  = v.nack_reg;
        nack_data = v.nack_data;
        base      = resp_count;
        ack_base  = ack_pulses;
        @(negedge clk);
        check_output($sformatf("v%0d_ready_before", idx), {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_rnw      = v.rnw;
        req_dev_addr = v.dev;
        req_reg_addr = v.rega;
        req_wdata    = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp(base + 1, 200, $sformatf("v%0d_resp", idx));
        #1;
        check_output($sformatf("v%0d_ready_after", idx), {31'd0, req_ready}, 32'd1);
        check_output($sformatf("v%0d_ctrl_idle", idx), {21'd0, ctrl_word}, 32'd0);
        repeat (3) @(posedge clk);
        check_output($sformatf("v%0d_resp_once", idx), resp_count - base, 32'd1);
        check_output($sformatf("v%0d_npulses", idx), nlog, v.npulses);
        for (int i = 0; i < v.npulses; i++) begin
            check_output($sformatf("v%0d_word%0d", idx, i), {21'd0, log_word[i]},
                         {21'd0, v.words[i]});
        end
        check_output($sformatf("v%0d_irq_acks", idx), ack_pulses - ack_base, v.npulses);
        check_output($sformatf("v%0d_rdata", idx), {24'd0, got_rdata}, {24'd0, v.rdata});
        check_output($sformatf("v%0d_nack", idx), {31'd0, got_nack}, {31'd0, v.nack});
        check_output($sformatf("v%0d_nack_byte", idx), {30'd0, got_nack_byte},
                     {30'd0, v.nack_byte});
        check_output($sformatf("v%0d_timeout", idx), {31'd0, got_timeout}, 32'd0);
        nack_reg  = 1'b0;
        nack_data = 1'b0;
    endtask

    // Hard stop in case the design locks up the run.
    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    // Main test sequence.
    initial begin
        int base;
        int ack_base;
        int first_resp;

        vecs[0] = '{1'b1, 7'h50, 8'h12, 8'h00, 1'b0, 1'b0, 4,
                    {11'h6A0, 11'h412, 11'h6A1, 11'h100, 11'h000}, 8'h3C, 1'b0, 2'd0};
        vecs[1] = '{1'b0, 7'h50, 8'h12, 8'hA5, 1'b0, 1'b0, 3,
                    {11'h6A0, 11'h412, 11'h5A5, 11'h000, 11'h000}, 8'h00, 1'b0, 2'd0};
        vecs[2] = '{1'b1, 7'h50, 8'h12, 8'h00, 1'b0, 1'b0, 4,
                    {11'h6A0, 11'h412, 11'h6A1, 11'h100, 11'h000}, 8'hA5, 1'b0, 2'd0};
        vecs[3] = '{1'b0, 7'h51, 8'h12, 8'h77, 1'b0, 1'b0, 2,
                    {11'h6A2, 11'h5FF, 11'h000, 11'h000, 11'h000}, 8'h00, 1'b1, 2'd0};
        vecs[4] = '{1'b1, 7'h50, 8'h34, 8'h00, 1'b1, 1'b0, 3,
                    {11'h6A0, 11'h434, 11'h5FF, 11'h000, 11'h000}, 8'h00, 1'b1, 2'd1};
        vecs[5] = '{1'b0, 7'h50, 8'h20, 8'h99, 1'b0, 1'b1, 4,
                    {11'h6A0, 11'h420, 11'h599, 11'h5FF, 11'h000}, 8'h00, 1'b1, 2'd2};
        vecs[6] = '{1'b0, 7'h50, 8'h7F, 8'hC3, 1'b0, 1'b0, 3,
                    {11'h6A0, 11'h47F, 11'h5C3, 11'h000, 11'h000}, 8'h00, 1'b0, 2'd0};
        vecs[7] = '{1'b1, 7'h50, 8'h7F, 8'h00, 1'b0, 1'b0, 4,
                    {11'h6A0, 11'h47F, 11'h6A1, 11'h100, 11'h000}, 8'hC3, 1'b0, 2'd0};
        vecs[8] = '{1'b1, 7'h51, 8'h12, 8'h00, 1'b0, 1'b0, 2,
                    {11'h6A2, 11'h5FF, 11'h000, 11'h000, 11'h000}, 8'h00, 1'b1, 2'd0};

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_rnw      = 1'b0;
        req_dev_addr = '0;
        req_reg_addr = '0;
        req_wdata    = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_ready", {31'd0, req_ready}, 32'd0);
        check_output("rst_cmd_pulse", {31'd0, cmd_pulse}, 32'd0);
        check_output("rst_ctrl", {21'd0, ctrl_word}, 32'd0);
        check_output("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_output("rst_irq_ack", {31'd0, irq_ack}, 32'd0);
        check_output("rst_resp_fields",
                     {19'd0, resp_rdata, resp_nack, resp_nack_byte, resp_timeout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_output("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Table of register transactions.
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(i, vecs[i]);
        end

        // Watchdog: IRQ never arrives, 15 WAIT cycles then DONE, no IRQ ack.
        @(posedge clk);
        clear_log();
        force_irq_low = 1'b1;
        base          = resp_count;
        ack_base      = ack_pulses;
        @(negedge clk);
        req_valid    = 1'b1;
        req_rnw      = 1'b0;
        req_dev_addr = 7'h50;
        req_reg_addr = 8'h12;
        req_wdata    = 8'hA5;
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp(base + 1, 100, "to_resp");
        #1;
        check_output("to_ready_after", {31'd0, req_ready}, 32'd1);
        check_output("to_resp_valid_low", {31'd0, resp_valid}, 32'd0);
        check_output("to_timeout", {31'd0, got_timeout}, 32'd1);
        check_output("to_nack", {31'd0, got_nack}, 32'd0);
        check_output("to_rdata", {24'd0, got_rdata}, 32'd0);
        check_output("to_npulses", nlog, 32'd1);
        check_output("to_latency", resp_cyc - log_cyc[0], 32'd16);
        check_output("to_no_irq_ack", ack_pulses - ack_base, 32'd0);
        check_output("to_timeout_held", {31'd0, resp_timeout}, 32'd1);
        @(posedge clk);
        force_irq_low = 1'b0;

        // Back-to-back: req_valid held across two requests.
        @(posedge clk);
        clear_log();
        base = resp_count;
        @(negedge clk);
        req_valid    = 1'b1;
        req_rnw      = 1'b0;
        req_dev_addr = 7'h50;
        req_reg_addr = 8'h05;
        req_wdata    = 8'h11;
        wait_log(1, 20, "b2b_first_issue");
        @(negedge clk);
        req_rnw   = 1'b1;
        req_wdata = 8'h00;
        wait_resp(base + 1, 200, "b2b_resp1");
        first_resp = resp_cyc;
        check_output("b2b_pulses_before_resp1", nlog, 32'd3);
        check_output("b2b_word0", {21'd0, log_word[0]}, 32'h6A0);
        check_output("b2b_word1", {21'd0, log_word[1]}, 32'h405);
        check_output("b2b_word2", {21'd0, log_word[2]}, 32'h511);
        check_output("b2b_rdata1", {24'd0, got_rdata}, 32'd0);
        wait_log(4, 20, "b2b_second_issue");
        @(negedge clk);
        req_valid = 1'b0;
        check_output("b2b_second_accept_cycle", log_cyc[3] - first_resp, 32'd2);
        wait_resp(base + 2, 200, "b2b_resp2");
        check_output("b2b_npulses", nlog, 32'd7);
        check_output("b2b_word3", {21'd0, log_word[3]}, 32'h6A0);
        check_output("b2b_word5", {21'd0, log_word[5]}, 32'h6A1);
        check_output("b2b_word6", {21'd0, log_word[6]}, 32'h100);
        check_output("b2b_rdata2", {24'd0, got_rdata}, 32'h11);

        // Reset in the middle of a byte: everything idles, no response.
        @(posedge clk);
        clear_log();
        base = resp_count;
        @(negedge clk);
        req_valid    = 1'b1;
        req_rnw      = 1'b0;
        req_dev_addr = 7'h50;
        req_reg_addr = 8'h30;
        req_wdata    = 8'h5E;
        @(negedge clk);
        req_valid = 1'b0;
        wait_log(2, 30, "mid_rst_issue");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("mid_rst_ctrl", {21'd0, ctrl_word}, 32'd0);
        check_output("mid_rst_cmd_pulse", {31'd0, cmd_pulse}, 32'd0);
        check_output("mid_rst_irq_ack", {31'd0, irq_ack}, 32'd0);
        check_output("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_output("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_output("mid_rst_ready_after", {31'd0, req_ready}, 32'd1);
        repeat (20) @(posedge clk);
        check_output("mid_rst_no_resp", resp_count - base, 32'd0);

        // A clean write after the abandoned transfer.
        apply_stimulus(9, vecs[1]);

        check_output("resp_ready_overlap", overlap, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
